spi_master_byte: RTL and testbench

//  Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. Upstream stage that drives the
//  SPI slave stage over SCK/SSEL/MOSI/MISO, all in the same clk domain.

---
 rtl/spi_pkg.sv | 30 +++
 rtl/spi_sck_tick.sv | 29 ++
 rtl/spi_master_byte.sv | 160 ++++++++++++++++
 tb/tb_spi_master_byte.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and sizing helpers for the byte-oriented SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    NEXT,
    HOLD,
    GAP
  } spi_mst_state_t;

  localparam int SPI_BYTE_W   = 8;
  localparam int SPI_BITCNT_W = 3;

  function automatic int spi_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // A count of 1 would give $clog2 == 0, so keep at least one bit.
  function automatic int spi_cnt_w(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/spi_sck_tick.sv
// rtl/spi_sck_tick.sv - half-period timer: one-cycle tick every CLK_DIV cycles while enabled.
module spi_sck_tick #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Held at zero while disabled so every enable starts a full half-period.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
    end else if (cnt_q == DIV_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == DIV_LAST);

endmodule

// File: rtl/spi_master_byte.sv
// rtl/spi_master_byte.sv - mode-0 MSB-first SPI master with a valid/ready byte stream host side.
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_last,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  SCK,
  output logic                  SSEL,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int CNT_W = spi_cnt_w(spi_max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP));
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);

  spi_mst_state_t              state_q;
  logic [CNT_W-1:0]            phase_cnt_q;
  logic [SPI_BITCNT_W-1:0]     bitcnt_q;
  // Only the bits still to be sent; bit 7 goes straight to MOSI on accept.
  logic [SPI_BYTE_W-2:0]       shreg_q;
  logic [SPI_BYTE_W-1:0]       rxsh_q;
  logic                        last_q;
  logic                        sck_q;
  logic                        ssel_q;
  logic                        mosi_q;
  logic [SPI_BYTE_W-1:0]       rx_data_q;
  logic                        rx_valid_q;
  logic                        busy_q;
  logic                        tx_ready_q;
  logic                        sck_tick;

  spi_sck_tick #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) u_sck_tick (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (state_q == XFER),
    .tick_o(sck_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      rxsh_q      <= '0;
      last_q      <= 1'b0;
      sck_q       <= 1'b0;
      ssel_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
    end else begin
      rx_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tx_valid && tx_ready_q) begin
            shreg_q     <= tx_data[SPI_BYTE_W-2:0];
            mosi_q      <= tx_data[SPI_BYTE_W-1];
            last_q      <= tx_last;
            ssel_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            phase_cnt_q <= '0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (phase_cnt_q == SETUP_LAST) begin
            phase_cnt_q <= '0;
            bitcnt_q    <= '0;
            state_q     <= XFER;
          end else begin
            phase_cnt_q <= phase_cnt_q + CNT_W'(1);
          end
        end
        XFER: begin
          if (sck_tick) begin
            sck_q <= ~sck_q;
            if (!sck_q) begin
              rxsh_q   <= {rxsh_q[SPI_BYTE_W-2:0], MISO};
              bitcnt_q <= bitcnt_q + SPI_BITCNT_W'(1);
            end else if (bitcnt_q == '0) begin
              // bitcnt has wrapped: this is the 8th falling edge, byte complete.
              rx_data_q  <= rxsh_q;
              rx_valid_q <= 1'b1;
              if (last_q) begin
                state_q <= HOLD;
              end else begin
                tx_ready_q <= 1'b1;
                state_q    <= NEXT;
              end
            end else begin
              mosi_q  <= shreg_q[SPI_BYTE_W-2];
              shreg_q <= {shreg_q[SPI_BYTE_W-3:0], 1'b0};
            end
          end
        end
        NEXT: begin
          if (tx_valid && tx_ready_q) begin
            shreg_q    <= tx_data[SPI_BYTE_W-2:0];
            mosi_q     <= tx_data[SPI_BYTE_W-1];
            last_q     <= tx_last;
            tx_ready_q <= 1'b0;
            state_q    <= XFER;
          end
        end
        HOLD: begin
          if (phase_cnt_q == HOLD_LAST) begin
            phase_cnt_q <= '0;
            ssel_q      <= 1'b1;
            state_q     <= GAP;
          end else begin
            phase_cnt_q <= phase_cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (phase_cnt_q == GAP_LAST) begin
            phase_cnt_q <= '0;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            phase_cnt_q <= phase_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign SCK      = sck_q;
  assign SSEL     = ssel_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// tb/tb_spi_master_byte.sv - directed self-checking bench for spi_master_byte.
module tb_spi_master_byte;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       SCK;
  logic       SSEL;
  logic       MOSI;
  logic       MISO;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_byte #(
    .CLK_DIV (4),
    .CS_SETUP(4),
    .CS_HOLD (4),
    .CS_GAP  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_last (tx_last),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .SCK     (SCK),
    .SSEL    (SSEL),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  // MISO source: loopback, or a slave that answers with resp0 then resp1.
  logic       miso_mode = 1'b0;
  logic [7:0] resp0 = 8'h00;
  logic [7:0] resp1 = 8'h00;
  int         resp_sel = 0;
  int         resp_bit = 0;
  assign MISO = miso_mode ? ((resp_sel == 0) ? resp0[7-resp_bit] : resp1[7-resp_bit]) : MOSI;

  logic        sck_p = 1'b0;
  logic        ssel_p = 1'b1;
  int          rise_cnt = 0;
  int          rx_cnt = 0;
  int          low_run = 0;
  int          hi_run = 0;
  int          last_low = 0;
  int          last_hi = 0;
  logic [7:0]  mosi_sh = 8'h00;
  logic [15:0] rx_hist = 16'h0000;

  always @(negedge clk) begin
    if (SCK && !sck_p) begin
      rise_cnt++;
      mosi_sh = {mosi_sh[6:0], MOSI};
    end
    if (!SCK && sck_p) begin
      if (resp_bit == 7) begin
        resp_bit = 0;
        resp_sel = 1 - resp_sel;
      end else begin
        resp_bit++;
      end
    end
    if (SSEL) begin
      resp_bit = 0;
      resp_sel = 0;
    end
    if (rx_valid) begin
      rx_cnt++;
      rx_hist = {rx_hist[7:0], rx_data};
    end
    if (!SSEL) begin
      if (ssel_p) begin
        last_hi = hi_run;
        hi_run  = 0;
      end
      low_run++;
    end else begin
      if (!ssel_p) begin
        last_low = low_run;
        low_run  = 0;
      end
      hi_run++;
    end
    sck_p  = SCK;
    ssel_p = SSEL;
  end

  // Slave stage model: 3-flop synchronisers, shifts MOSI on SCK rise, LED follows bit 0.
  logic [2:0] s_sck = 3'b000;
  logic [2:0] s_ssel = 3'b111;
  logic [2:0] s_mosi = 3'b000;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_byte = 8'h00;
  int         s_bits = 0;
  int         s_got = 0;
  logic       s_led = 1'b0;

  always @(posedge clk) begin
    s_sck  <= {s_sck[1:0], SCK};
    s_ssel <= {s_ssel[1:0], SSEL};
    s_mosi <= {s_mosi[1:0], MOSI};
    if (s_ssel[2]) begin
      s_bits <= 0;
    end else if (s_sck[2:1] == 2'b01) begin
      s_sh <= {s_sh[6:0], s_mosi[2]};
      if (s_bits == 7) begin
        s_bits <= 0;
        s_got  <= s_got + 1;
        s_byte <= {s_sh[6:0], s_mosi[2]};
        s_led  <= s_mosi[2];
      end else begin
        s_bits <= s_bits + 1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 1000) begin
      step();
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: tx_ready=%b required 1 within 1000 cycles", tx_ready);
    end
    step();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b required 0 within 2000 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (SSEL !== 1'b1) begin errors++; $display("FAIL reset_ssel: got %b required 1", SSEL); end
    checks++; if (SCK !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b required 0", SCK); end
    checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b required 0", MOSI); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_loopback();
    int lat;
    int rc;
    miso_mode = 1'b0;
    rc = rx_cnt;
    send(8'h5A, 1'b1);
    lat = 0;
    while (!rx_valid && lat < 200) begin
      step();
      lat++;
    end
    checks++; if (lat != 68) begin errors++; $display("FAIL single_latency: got %0d required 68", lat); end
    wait_idle();
    checks++; if (mosi_sh !== 8'h5A) begin errors++; $display("FAIL single_mosi_bits: got %h required 5a", mosi_sh); end
    checks++; if (rx_hist[7:0] !== 8'h5A || rx_cnt != rc + 1) begin errors++; $display("FAIL single_rx: got %h count %0d required 5a count 1", rx_hist[7:0], rx_cnt - rc); end
    checks++; if (last_low != 72) begin errors++; $display("FAIL single_ssel_low: got %0d required 72", last_low); end
  endtask

  task automatic test_two_byte_burst();
    int rc;
    miso_mode = 1'b1;
    resp0 = 8'h05;
    resp1 = 8'h0A;
    rc = rx_cnt;
    send(8'h03, 1'b0);
    send(8'hC3, 1'b1);
    wait_idle();
    checks++; if (rx_cnt != rc + 2 || rx_hist !== 16'h050A) begin errors++; $display("FAIL burst_rx: got %h count %0d required 050a count 2", rx_hist, rx_cnt - rc); end
    checks++; if (last_low != 137) begin errors++; $display("FAIL burst_ssel_low: got %0d required 137", last_low); end
    miso_mode = 1'b0;
  endtask

  task automatic test_stall_next();
    int n;
    int bad;
    int rc;
    send(8'h81, 1'b0);
    n = 0;
    while (!tx_ready && n < 200) begin
      step();
      n++;
    end
    rc  = rise_cnt;
    bad = 0;
    repeat (50) begin
      step();
      if (SSEL !== 1'b0 || SCK !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_levels: got %0d bad cycles required 0", bad); end
    checks++; if (rise_cnt != rc) begin errors++; $display("FAIL stall_sck_edges: got %0d rises required 0", rise_cnt - rc); end
    send(8'h7E, 1'b1);
    wait_idle();
    checks++; if (rx_hist !== 16'h817E) begin errors++; $display("FAIL stall_rx: got %h required 817e", rx_hist); end
  endtask

  task automatic test_back_to_back();
    int n;
    int bad;
    tx_data  = 8'hA5;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h3C;
    n   = 0;
    bad = 0;
    while (!tx_ready && n < 500) begin
      step();
      n++;
      if (busy && tx_ready) bad++;
    end
    step();
    tx_valid = 1'b0;
    wait_idle();
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ready_in_hold_gap: got %0d cycles required 0", bad); end
    checks++; if (last_hi != 5) begin errors++; $display("FAIL b2b_ssel_gap: got %0d required 5", last_hi); end
    checks++; if (rx_hist !== 16'hA53C) begin errors++; $display("FAIL b2b_rx: got %h required a53c", rx_hist); end
  endtask

  task automatic test_slave_integration();
    int g;
    g = s_got;
    send(8'h01, 1'b1);
    wait_idle();
    repeat (5) step();
    checks++; if (s_got != g + 1) begin errors++; $display("FAIL slave_flag_count: got %0d required 1", s_got - g); end
    checks++; if (s_byte !== 8'h01) begin errors++; $display("FAIL slave_byte: got %h required 01", s_byte); end
    checks++; if (s_led !== 1'b1) begin errors++; $display("FAIL slave_led: got %b required 1", s_led); end
  endtask

  task automatic test_reset_mid();
    int n;
    int rc;
    int r0;
    rc = rx_cnt;
    r0 = rise_cnt;
    send(8'h5A, 1'b1);
    n = 0;
    while (rise_cnt < r0 + 3 && n < 200) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    checks++; if (SSEL !== 1'b1) begin errors++; $display("FAIL midrst_ssel: got %b required 1", SSEL); end
    checks++; if (SCK !== 1'b0) begin errors++; $display("FAIL midrst_sck: got %b required 0", SCK); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_tx_ready: got %b required 1", tx_ready); end
    rst = 1'b0;
    repeat (80) step();
    checks++; if (rx_cnt != rc) begin errors++; $display("FAIL midrst_no_rx_valid: got %0d pulses required 0", rx_cnt - rc); end
    send(8'hFF, 1'b1);
    wait_idle();
    checks++; if (rx_hist[7:0] !== 8'hFF || rx_cnt != rc + 1) begin errors++; $display("FAIL midrst_next_rx: got %h count %0d required ff count 1", rx_hist[7:0], rx_cnt - rc); end
  endtask

  initial begin
    test_reset();
    test_single_loopback();
    test_two_byte_burst();
    test_stall_next();
    test_back_to_back();
    test_slave_integration();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
